// File: rtl/regbank32_writer_if.sv
// Write/clear handshake bundle for the 32-entry register bank.
interface regbank32_writer_if #(
  parameter int WIDTH = 32
);
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic             busy;
  logic             clr_done;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, busy, clr_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, busy, clr_done
  );
endinterface

// File: rtl/regbank32_writer.sv
// Write side of the 32x32 register file: handshaked single writes plus a
// sequenced one-register-per-cycle bulk clear; all registers exposed in parallel.
module regbank32_writer #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regbank32_writer_if.slave   bus,
  output logic [WIDTH-1:0]    q0,  q1,  q2,  q3,  q4,  q5,  q6,  q7,
  output logic [WIDTH-1:0]    q8,  q9,  q10, q11, q12, q13, q14, q15,
  output logic [WIDTH-1:0]    q16, q17, q18, q19, q20, q21, q22, q23,
  output logic [WIDTH-1:0]    q24, q25, q26, q27, q28, q29, q30, q31
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.wr_ready <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      bus.clr_done <= 1'b0;
      case (state)
        IDLE: begin
          // A write coinciding with clr_req still lands; the clear reaches it later.
          if (bus.wr_valid && bus.wr_ready &&
              !(ZERO_REG && bus.wr_addr == 5'd0))
            regs[bus.wr_addr] <= bus.wr_data;
          if (bus.clr_req) begin
            state        <= CLEAR;
            cnt          <= 5'd0;
            bus.busy     <= 1'b1;
            bus.wr_ready <= 1'b0;
          end else begin
            bus.wr_ready <= 1'b1;
          end
        end
        CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.wr_ready <= 1'b1;
            bus.clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign q0  = regs[0];   assign q1  = regs[1];   assign q2  = regs[2];   assign q3  = regs[3];
  assign q4  = regs[4];   assign q5  = regs[5];   assign q6  = regs[6];   assign q7  = regs[7];
  assign q8  = regs[8];   assign q9  = regs[9];   assign q10 = regs[10];  assign q11 = regs[11];
  assign q12 = regs[12];  assign q13 = regs[13];  assign q14 = regs[14];  assign q15 = regs[15];
  assign q16 = regs[16];  assign q17 = regs[17];  assign q18 = regs[18];  assign q19 = regs[19];
  assign q20 = regs[20];  assign q21 = regs[21];  assign q22 = regs[22];  assign q23 = regs[23];
  assign q24 = regs[24];  assign q25 = regs[25];  assign q26 = regs[26];  assign q27 = regs[27];
  assign q28 = regs[28];  assign q29 = regs[29];  assign q30 = regs[30];  assign q31 = regs[31];

endmodule

// File: tb/tb_regbank32_writer.sv
// Directed bench for regbank32_writer; a ZERO_REG=0 copy shadows the same stimulus.
module tb_regbank32_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regbank32_writer_if #(.WIDTH(32)) bus0 ();
  regbank32_writer_if #(.WIDTH(32)) bus1 ();

  assign bus1.wr_valid = bus0.wr_valid;
  assign bus1.wr_addr  = bus0.wr_addr;
  assign bus1.wr_data  = bus0.wr_data;
  assign bus1.clr_req  = bus0.clr_req;

  logic [31:0] qa [32];
  logic [31:0] qb [32];

  regbank32_writer #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .q0(qa[0]),   .q1(qa[1]),   .q2(qa[2]),   .q3(qa[3]),
    .q4(qa[4]),   .q5(qa[5]),   .q6(qa[6]),   .q7(qa[7]),
    .q8(qa[8]),   .q9(qa[9]),   .q10(qa[10]), .q11(qa[11]),
    .q12(qa[12]), .q13(qa[13]), .q14(qa[14]), .q15(qa[15]),
    .q16(qa[16]), .q17(qa[17]), .q18(qa[18]), .q19(qa[19]),
    .q20(qa[20]), .q21(qa[21]), .q22(qa[22]), .q23(qa[23]),
    .q24(qa[24]), .q25(qa[25]), .q26(qa[26]), .q27(qa[27]),
    .q28(qa[28]), .q29(qa[29]), .q30(qa[30]), .q31(qa[31])
  );

  regbank32_writer #(.WIDTH(32), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .q0(qb[0]),   .q1(qb[1]),   .q2(qb[2]),   .q3(qb[3]),
    .q4(qb[4]),   .q5(qb[5]),   .q6(qb[6]),   .q7(qb[7]),
    .q8(qb[8]),   .q9(qb[9]),   .q10(qb[10]), .q11(qb[11]),
    .q12(qb[12]), .q13(qb[13]), .q14(qb[14]), .q15(qb[15]),
    .q16(qb[16]), .q17(qb[17]), .q18(qb[18]), .q19(qb[19]),
    .q20(qb[20]), .q21(qb[21]), .q22(qb[22]), .q23(qb[23]),
    .q24(qb[24]), .q25(qb[25]), .q26(qb[26]), .q27(qb[27]),
    .q28(qb[28]), .q29(qb[29]), .q30(qb[30]), .q31(qb[31])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] or_except(input int skip);
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) if (i != skip) acc |= qa[i];
    return acc;
  endfunction

  int busy_cycles;

  initial begin
    bus0.wr_valid = 1'b0;
    bus0.wr_addr  = 5'd0;
    bus0.wr_data  = 32'h0;
    bus0.clr_req  = 1'b0;

    // Reset state
    #12;
    check("rst_wr_ready", {31'b0, bus0.wr_ready}, 32'd0);
    check("rst_busy",     {31'b0, bus0.busy},     32'd0);
    check("rst_clr_done", {31'b0, bus0.clr_done}, 32'd0);
    check("rst_q_all",    or_except(-1),          32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_wr_ready", {31'b0, bus0.wr_ready}, 32'd1);

    // Single write
    bus0.wr_valid = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
    tick();
    check("w5_q5",     qa[5],        32'hDEADBEEF);
    check("w5_others", or_except(5), 32'h0);
    check("w5_ready",  {31'b0, bus0.wr_ready}, 32'd1);

    // Write to register 0 on both variants
    bus0.wr_addr = 5'd0; bus0.wr_data = 32'h12345678;
    check("w0_ready", {31'b0, bus0.wr_ready}, 32'd1);
    tick();
    check("w0_zero_reg", qa[0], 32'h0);
    check("w0_plain",    qb[0], 32'h12345678);

    // Back-to-back writes 1..31
    for (int i = 1; i < 32; i++) begin
      bus0.wr_addr = 5'(i);
      bus0.wr_data = 32'(i) * 32'h01010101;
      check("b2b_ready", {31'b0, bus0.wr_ready}, 32'd1);
      tick();
      check($sformatf("b2b_q%0d", i), qa[i], 32'(i) * 32'h01010101);
    end
    bus0.wr_valid = 1'b0;
    check("b2b_q31", qa[31], 32'h1F1F1F1F);
    check("b2b_q0",  qa[0],  32'h0);

    // Bulk clear with a stray write attempt at clear cycle 10
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 32; k++) begin
      if (bus0.busy === 1'b1 && bus0.wr_ready === 1'b0) busy_cycles++;
      check("clr_done_early", {31'b0, bus0.clr_done}, 32'd0);
      if (k == 10) begin
        bus0.wr_valid = 1'b1; bus0.wr_addr = 5'd25; bus0.wr_data = 32'hFFFFFFFF;
      end
      tick();
      if (k == 10) begin
        bus0.wr_valid = 1'b0;
        check("clr_ignored_write", qa[25], 32'h19191919);
      end
      check($sformatf("clr_q%0d", k), qa[k], 32'h0);
      if (k > 0 && k < 31)
        check($sformatf("clr_hold_q%0d", k + 1), qa[k + 1], 32'(k + 1) * 32'h01010101);
    end
    check("clr_busy_cycles", 32'(busy_cycles), 32'd32);
    check("clr_end_busy",    {31'b0, bus0.busy},     32'd0);
    check("clr_end_ready",   {31'b0, bus0.wr_ready}, 32'd1);
    check("clr_done_pulse",  {31'b0, bus0.clr_done}, 32'd1);
    tick();
    check("clr_done_once",   {31'b0, bus0.clr_done}, 32'd0);

    // Write and clr_req on the same edge
    bus0.wr_valid = 1'b1; bus0.wr_addr = 5'd7; bus0.wr_data = 32'hA5A5A5A5;
    bus0.clr_req = 1'b1;
    tick();
    bus0.wr_valid = 1'b0; bus0.clr_req = 1'b0;
    check("same_edge_q7",   qa[7], 32'hA5A5A5A5);
    check("same_edge_busy", {31'b0, bus0.busy}, 32'd1);
    repeat (7) tick();
    check("same_edge_q7_hold", qa[7], 32'hA5A5A5A5);
    tick();
    check("same_edge_q7_clr", qa[7], 32'h0);
    repeat (24) tick();
    check("same_edge_done", {31'b0, bus0.clr_done}, 32'd1);
    tick();

    // Asynchronous reset in the middle of a clear
    bus0.wr_valid = 1'b1; bus0.wr_addr = 5'd20; bus0.wr_data = 32'h00000055;
    tick();
    bus0.wr_valid = 1'b0;
    check("pre_q20", qa[20], 32'h55);
    bus0.clr_req = 1'b1;
    tick();
    bus0.clr_req = 1'b0;
    repeat (15) tick();
    check("mid_q20",   qa[20], 32'h55);
    check("mid_busy",  {31'b0, bus0.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_q20",   qa[20], 32'h0);
    check("async_busy",  {31'b0, bus0.busy},     32'd0);
    check("async_ready", {31'b0, bus0.wr_ready}, 32'd0);
    check("async_q_all", or_except(-1), 32'h0);
    repeat (3) begin
      tick();
      check("async_no_done", {31'b0, bus0.clr_done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rerel_ready", {31'b0, bus0.wr_ready}, 32'd1);
    check("rerel_done",  {31'b0, bus0.clr_done}, 32'd0);
    bus0.wr_valid = 1'b1; bus0.wr_addr = 5'd9; bus0.wr_data = 32'h99999999;
    tick();
    bus0.wr_valid = 1'b0;
    check("rerel_q9",     qa[9],        32'h99999999);
    check("rerel_others", or_except(9), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
